wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, power of two ≥2: number of MDU result buffer entries.
REQ-002 SHALL have one clock and asynchronous active-low reset: clk input 1 (all state changes on rising edge); rst input 1 (active-low asynchronous reset).
REQ-003 pipe_we  input 1: main pipeline writeback request.
REQ-004 pipe_waddr  input 5: main pipeline destination register.
REQ-005 pipe_wdata  input 32: main pipeline result.
REQ-006 mdu_valid  input 1: multiply/divide unit offers a result.
REQ-007 mdu_waddr  input 5: MDU destination register.
REQ-008 mdu_wdata  input 32: MDU result.
REQ-009 mdu_ready  output 1: buffer can accept an MDU result this cycle.
REQ-010 we  output 1: regfile write enable (registered).
REQ-011 waddr  output 5: regfile write address (registered).
REQ-012 wdata  output 32: regfile write data (registered).
REQ-013 raddr1, raddr2  input 5 each: decode-stage read addresses for forwarding lookup.
REQ-014 fwd_hit1, fwd_hit2  output 1 each: a pending write to raddrN exists.
REQ-015 fwd_data1, fwd_data2  output 32 each: newest pending value for raddrN.

Function
REQ-016 SHALL treat the pipeline write as valid only when pipe_we=1 and pipe_waddr≠0.
REQ-017 SHALL enqueue an MDU result on a rising edge with mdu_valid=1 and mdu_ready=1; mdu_waddr=0 results are handshaken but discarded.
REQ-018 mdu_ready SHALL equal (count<DEPTH), derived from registered count only; mdu_valid while mdu_ready=0 is ignored and the MDU holds.
REQ-019 Each cycle the output register SHALL load: valid pipeline write if present (priority); else FIFO head, dequeued the same edge; else we=0 with waddr/wdata held.
REQ-020 Pipeline-to-regfile latency SHALL be exactly 1 cycle; FIFO head SHALL drain in the first cycle without a valid pipeline write.
REQ-021 A valid pipeline write SHALL cancel (mark dead) every FIFO entry with the same address; dead entries dequeue in order with we=0 for that slot being skipped (no regfile write, dequeue still consumes no output cycle).
REQ-022 Simultaneous enqueue and dequeue SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-023 MDU result arriving the same edge as a matching-address pipeline write SHALL be enqueued live (MDU is newer).
REQ-024 fwd_hitN SHALL be combinational: match against live FIFO entries (youngest wins) then the output register (we=1, waddr=raddrN); raddrN=0 SHALL never hit.
REQ-025 fwd_dataN SHALL be 0 when fwd_hitN=0.

Reset
REQ-026 While rst=0: count=0, pointers=0, all entries dead, we=0, waddr=0, wdata=0, mdu_ready=1 asynchronously.
REQ-027 Reset asserted mid-operation SHALL discard all pending entries with no regfile write issued.

Configuration
REQ-028 Macro WBQ_FWD_EN defined: forwarding per REQ-024/025.
REQ-029 WBQ_FWD_EN undefined: no lookup logic; fwd_hit1/2=0, fwd_data1/2=0 constant; all other behaviour unchanged.

Verification
REQ-030 Reset release, pipe_we=1 waddr=5 wdata=0x11 -> next cycle we=1 waddr=5 wdata=0x11.
REQ-031 Enqueue 4 MDU results (r8..r11) with pipe_we=1 to r2 throughout -> mdu_ready=0 after 4th; drop pipe_we -> r8..r11 written on 4 consecutive cycles, mdu_ready=1 after first drain.
REQ-032 MDU r9=0xAA queued, pipe writes r9=0xBB -> only 0xBB reaches regfile; raddr1=9 fwd_data1=0xBB.
REQ-033 MDU r7=0x1 then r7=0x2 queued, raddr2=7 -> fwd_hit2=1, fwd_data2=0x2; raddr2=0 -> fwd_hit2=0.
REQ-034 FIFO holding 3 entries, rst pulsed low mid-cycle -> we=0, mdu_ready=1 immediately, no write after release.
REQ-035 Build without WBQ_FWD_EN, repeat REQ-033 -> fwd_hit2=0, fwd_data2=0, regfile writes unchanged.

Source files
------------

// File: rtl/wb_queue.sv
// wb_queue: regfile writeback merger with MDU result buffer and forwarding; optional lookup enabled by WBQ_FWD_EN
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_waddr,
  input  logic [31:0] mdu_wdata,
  output logic        mdu_ready,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0]    q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [DEPTH-1:0] q_live;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          pipe_ok, head_live, deq, enq;
  assign pipe_ok   = pipe_we && pipe_waddr != 5'd0;
  assign head_live = q_live[rd_ptr];
  assign mdu_ready = count < (AW+1)'(DEPTH);
  // dead heads need no output slot, so they retire even under a pipeline write
  assign deq       = count != '0 && (!head_live || !pipe_ok);
  assign enq       = mdu_valid && mdu_ready && mdu_waddr != 5'd0;
  // queue control: cancel matching entries, then the same-edge MDU entry lands live
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      q_live <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (pipe_ok && q_addr[i] == pipe_waddr) q_live[i] <= 1'b0;
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      if (enq) begin
        q_live[wr_ptr] <= 1'b1;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      count <= count + (AW+1)'(enq) - (AW+1)'(deq);
    end
  // payload storage needs no reset; only entries covered by count are ever read
  always_ff @(posedge clk)
    if (enq) begin
      q_addr[wr_ptr] <= mdu_waddr;
      q_data[wr_ptr] <= mdu_wdata;
    end
  // regfile write register: pipeline first, then a live FIFO head, else idle with held address/data
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (pipe_ok) begin
      we    <= 1'b1;
      waddr <= pipe_waddr;
      wdata <= pipe_wdata;
    end else if (deq && head_live) begin
      we    <= 1'b1;
      waddr <= q_addr[rd_ptr];
      wdata <= q_data[rd_ptr];
    end else
      we <= 1'b0;
`ifdef WBQ_FWD_EN
  logic [AW-1:0] idx;
  // lookup: output register first, then FIFO oldest-to-youngest so the youngest live match wins
  always_comb begin
    fwd_hit1  = we && raddr1 != 5'd0 && waddr == raddr1;
    fwd_data1 = fwd_hit1 ? wdata : 32'd0;
    fwd_hit2  = we && raddr2 != 5'd0 && waddr == raddr2;
    fwd_data2 = fwd_hit2 ? wdata : 32'd0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if ((AW+1)'(i) < count && q_live[idx] && raddr1 != 5'd0 && q_addr[idx] == raddr1) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = q_data[idx];
      end
      if ((AW+1)'(i) < count && q_live[idx] && raddr2 != 5'd0 && q_addr[idx] == raddr2) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = q_data[idx];
      end
    end
  end
`else
  logic fwd_unused;
  assign fwd_unused = ^{raddr1, raddr2};
  assign fwd_hit1   = 1'b0;
  assign fwd_hit2   = 1'b0;
  assign fwd_data1  = 32'd0;
  assign fwd_data2  = 32'd0;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed checks of writeback priority, MDU buffering, cancellation, forwarding and reset
module tb_wb_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we, mdu_valid, mdu_ready, we, fwd_hit1, fwd_hit2;
  logic [4:0]  pipe_waddr, mdu_waddr, waddr, raddr1, raddr2;
  logic [31:0] pipe_wdata, mdu_wdata, wdata, fwd_data1, fwd_data2;
  int checks = 0;
  int errors = 0;
`ifdef WBQ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .mdu_valid(mdu_valid), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata), .mdu_ready(mdu_ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pipe(input logic e, input logic [4:0] a, input logic [31:0] d);
    pipe_we = e; pipe_waddr = a; pipe_wdata = d;
  endtask
  task automatic mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
    mdu_valid = v; mdu_waddr = a; mdu_wdata = d;
  endtask
  task automatic wr(input string tag, input logic e, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"}, we, e);
    chk({tag, ".waddr"}, waddr, a);
    chk({tag, ".wdata"}, wdata, d);
  endtask
  initial begin
    rst = 1'b0; raddr1 = 0; raddr2 = 0;
    pipe(0, 0, 0); mdu(0, 0, 0);
    #3;
    wr("reset", 0, 0, 0);
    chk("reset.ready", mdu_ready, 1);
    #9 rst = 1'b1;
    // single pipeline write lands one cycle later
    pipe(1, 5, 32'h11);
    step();
    wr("pipe1", 1, 5, 32'h11);
    // fill the buffer while the pipeline keeps the output busy
    pipe(1, 2, 32'h22);
    for (int i = 0; i < 4; i++) begin
      mdu(1, 5'(8 + i), 32'h80 + 32'(i));
      step();
      chk($sformatf("fill%0d.ready", i), mdu_ready, i < 3);
      wr($sformatf("fill%0d", i), 1, 2, 32'h22);
    end
    mdu(1, 12, 32'hC0);
    step();
    chk("full.ready", mdu_ready, 0);
    pipe(0, 0, 0); mdu(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      wr($sformatf("drain%0d", i), 1, 5'(8 + i), 32'h80 + 32'(i));
      chk($sformatf("drain%0d.ready", i), mdu_ready, 1);
    end
    step();
    wr("drained", 0, 11, 32'h83);
    // stale MDU value cancelled by a newer pipeline write
    mdu(1, 9, 32'hAA);
    step();
    chk("r9q.we", we, 0);
    mdu(0, 0, 0); pipe(1, 9, 32'hBB);
    step();
    wr("r9pipe", 1, 9, 32'hBB);
    raddr1 = 9;
    #1;
    chk("r9.hit1", fwd_hit1, FWD);
    chk("r9.fwd1", fwd_data1, FWD ? 32'hBB : 32'h0);
    pipe(0, 0, 0);
    step();
    chk("r9dead.we", we, 0);
    step();
    chk("r9dead2.we", we, 0);
    raddr1 = 0;
    // two queued results for r7; youngest forwards
    pipe(1, 3, 32'h33);
    mdu(1, 7, 32'h1);
    step();
    mdu(1, 7, 32'h2);
    step();
    mdu(0, 0, 0);
    raddr2 = 7;
    #1;
    chk("r7.hit2", fwd_hit2, FWD);
    chk("r7.fwd2", fwd_data2, FWD ? 32'h2 : 32'h0);
    raddr2 = 0;
    #1;
    chk("r0.hit2", fwd_hit2, 0);
    chk("r0.fwd2", fwd_data2, 0);
    raddr2 = 7;
    pipe(0, 0, 0);
    step();
    wr("r7a", 1, 7, 32'h1);
    chk("r7a.fwd2", fwd_data2, FWD ? 32'h2 : 32'h0);
    step();
    wr("r7b", 1, 7, 32'h2);
    chk("r7b.fwd2", fwd_data2, FWD ? 32'h2 : 32'h0);
    raddr2 = 0;
    // MDU result on the same edge as a matching pipeline write stays live
    pipe(1, 4, 32'h40); mdu(1, 4, 32'h41);
    step();
    wr("r4pipe", 1, 4, 32'h40);
    pipe(0, 0, 0); mdu(0, 0, 0);
    step();
    wr("r4mdu", 1, 4, 32'h41);
    // discarded r0 MDU result
    mdu(1, 0, 32'hDEAD);
    step();
    mdu(0, 0, 0);
    step();
    chk("r0mdu.we", we, 0);
    // reset mid-operation with three entries queued
    pipe(1, 1, 32'h10);
    for (int i = 0; i < 3; i++) begin
      mdu(1, 5'(20 + i), 32'(i));
      step();
    end
    mdu(0, 0, 0);
    #2 rst = 1'b0;
    #1;
    wr("midrst", 0, 0, 0);
    chk("midrst.ready", mdu_ready, 1);
    pipe(0, 0, 0);
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("postrst%0d.we", i), we, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
